// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback logic for the 5-stage MIPS core.
// Captures MEM-stage results, extracts and extends load data, selects the
// writeback source, drives the register-file write port (A3, WD, RFWr), and
// counts retired instructions for debug and CPI measurement.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wbsel,
  input  logic [2:0]       mem_ldtype,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      mem_link,
  output logic             RFWr,
  output logic [4:0]       A3,
  output logic [31:0]      WD,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retired
);

  // Writeback source select codes; code 3 is reserved and behaves as ALU.
  localparam logic [1:0] WBSEL_ALU  = 2'd0;
  localparam logic [1:0] WBSEL_LOAD = 2'd1;
  localparam logic [1:0] WBSEL_LINK = 2'd2;

  // Load type codes; 5..7 behave as LW.
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  // MEM/WB pipeline register: current and next state.
  logic        valid_q,    valid_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q,       rd_d;
  logic [1:0]  wbsel_q,    wbsel_d;
  logic [2:0]  ldtype_q,   ldtype_d;
  logic [31:0] alu_q,      alu_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [31:0] link_q,     link_d;

  // Retired-instruction counter.
  logic [CNT_W-1:0] retired_q, retired_d;

  // Load extraction intermediates.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Next pipeline-register contents: flush inserts a bubble, stall holds,
  // otherwise the MEM-stage fields are captured.
  always_comb begin
    // NOTE: every output of this block gets a default first so that paths
    // not assigned below hold cleanly instead of inferring latches.
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wbsel_d    = wbsel_q;
    ldtype_d   = ldtype_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    link_d     = link_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      wbsel_d    = '0;
      ldtype_d   = '0;
      alu_d      = '0;
      rdata_d    = '0;
      link_d     = '0;
    end else if (!stall) begin
      valid_d    = mem_valid;
      regwrite_d = mem_regwrite;
      rd_d       = mem_rd;
      wbsel_d    = mem_wbsel;
      ldtype_d   = mem_ldtype;
      alu_d      = mem_alu;
      rdata_d    = mem_rdata;
      link_d     = mem_link;
    end
  end

  // The instruction in WB leaves on any non-stalled edge; a flush only
  // kills the incoming instruction, so it does not block the count.
  always_comb begin
    retired_d = retired_q;
    if (!stall && valid_q) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Synchronous reset has priority over flush, stall and load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wbsel_q    <= '0;
      ldtype_q   <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      link_q     <= '0;
      retired_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wbsel_q    <= wbsel_d;
      ldtype_q   <= ldtype_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      link_q     <= link_d;
      retired_q  <= retired_d;
    end
  end

  // Big-endian byte and halfword lane selection from the registered word.
  always_comb begin
    ld_byte = rdata_q[31:24];
    unique case (alu_q[1:0])
      2'd0: ld_byte = rdata_q[31:24];
      2'd1: ld_byte = rdata_q[23:16];
      2'd2: ld_byte = rdata_q[15:8];
      2'd3: ld_byte = rdata_q[7:0];
    endcase
    // alu_q[0] is ignored for halfwords; alignment is checked upstream.
    ld_half = alu_q[1] ? rdata_q[15:0] : rdata_q[31:16];
  end

  // Sign or zero extension according to the load type.
  always_comb begin
    ld_data = rdata_q;
    case (ldtype_q)
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_data = {24'd0, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_data = {16'd0, ld_half};
      LD_LW:   ld_data = rdata_q;
      default: ld_data = rdata_q;
    endcase
  end

  // Writeback data source select; the reserved code falls back to ALU.
  always_comb begin
    WD = alu_q;
    case (wbsel_q)
      WBSEL_ALU:  WD = alu_q;
      WBSEL_LOAD: WD = ld_data;
      WBSEL_LINK: WD = link_q;
      default:    WD = alu_q;
    endcase
  end

  // Register-file write port and status outputs, all from registered state.
  // RFWr stays asserted through a stall: the repeated identical write keeps
  // the register-file bypass path valid.
  assign RFWr     = valid_q & regwrite_q & (rd_q != 5'd0);
  assign A3       = rd_q;
  assign wb_valid = valid_q;
  assign retired  = retired_q;

endmodule
